// File: rtl/iact_spad_loader_pkg.sv
// ----------------------------------------------------------------------------
// iact_pkg -- shared definitions for the input-activation scratchpad loader.
//
// Holds the word widths, the terminator zero-codes, the default scratchpad
// depths, the 1-bit stream FSM encoding and the terminator-rule selector
// used by iact_spad_stream.
// ----------------------------------------------------------------------------
package iact_pkg;

   localparam int ADDR_W         = 8;
   localparam int DATA_W         = 13;

   localparam int ADDR_DEPTH_DEF = 9;
   localparam int DATA_DEPTH_DEF = 16;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [DATA_W-1:0] DATA_ZERO = '0;

   // Stream FSM encoding, kept as plain constants for legacy compatibility.
   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   // How a stream recognises its terminator word.
   typedef enum logic {
      TERM_ANY_ZERO       = 1'b0,  // every zero-code word terminates
      TERM_ZERO_NOT_FIRST = 1'b1   // a zero-code at slot 0 is a normal word
   } term_rule_e;

endpackage

// File: rtl/iact_spad_loader_if.sv
// ----------------------------------------------------------------------------
// iact_spad_loader_if -- the two valid/ready streams from the cluster iact
// switch into one PE's iact scratchpad loader.
//
//   iact_address_in_{valid,ready,bits}  8-bit CSC address stream
//   iact_data_in_{valid,ready,bits}     13-bit CSC data stream
//
// master: switch side (drives valid/bits), slave: loader side (drives ready).
// ----------------------------------------------------------------------------
interface iact_spad_loader_if;
   import iact_pkg::*;

   logic              iact_address_in_valid;
   logic              iact_address_in_ready;
   logic [ADDR_W-1:0] iact_address_in_bits;

   logic              iact_data_in_valid;
   logic              iact_data_in_ready;
   logic [DATA_W-1:0] iact_data_in_bits;

   modport master (
      output iact_address_in_valid, iact_address_in_bits,
      input  iact_address_in_ready,
      output iact_data_in_valid, iact_data_in_bits,
      input  iact_data_in_ready
   );

   modport slave (
      input  iact_address_in_valid, iact_address_in_bits,
      output iact_address_in_ready,
      input  iact_data_in_valid, iact_data_in_bits,
      output iact_data_in_ready
   );

endinterface

// File: rtl/iact_spad_stream.sv
// ----------------------------------------------------------------------------
// iact_spad_stream -- one stream of the iact scratchpad loader: LOAD/DONE FSM,
// write pointer, stored-word count and register-file scratchpad.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous re-arm; a transfer in the same cycle is dropped
//   in_valid/in_ready/in_bits   upstream valid/ready word
//   rd_idx/rd_bits              combinational scratchpad read
//   count        words stored, terminator excluded (DEPTH on overflow)
//   done         FSM is in DONE
//   ovf_hit      this cycle's transfer fills the last slot without a
//                terminator (the edge that ends the stream by overflow)
// ----------------------------------------------------------------------------
module iact_spad_stream
   import iact_pkg::*;
#(
   parameter int         W         = ADDR_W,
   parameter int         DEPTH     = ADDR_DEPTH_DEF,
   parameter logic [W-1:0] ZERO_CODE = '0,
   parameter term_rule_e TERM_RULE = TERM_ANY_ZERO,
   localparam int        PTR_W     = $clog2(DEPTH),
   localparam int        CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_bits,
   input  logic [PTR_W-1:0] rd_idx,
   output logic [W-1:0]     rd_bits,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             ovf_hit
);

   logic [0:0]       state;
   logic [PTR_W-1:0] wr_ptr;
   logic [W-1:0]     mem [DEPTH];

   logic xfer;
   logic is_term;
   logic last_slot;

   assign in_ready  = (state == ST_LOAD);
   assign done      = (state == ST_DONE);

   // A clear cycle wins over a simultaneous handshake.
   assign xfer      = in_valid && in_ready && !clear;
   assign is_term   = (in_bits == ZERO_CODE) &&
                      ((TERM_RULE == TERM_ANY_ZERO) || (wr_ptr != '0));
   assign last_slot = (wr_ptr == PTR_W'(DEPTH - 1));
   assign ovf_hit   = xfer && !is_term && last_slot;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_LOAD;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         state  <= ST_LOAD;
         wr_ptr <= '0;
         count  <= '0;
      end else if (xfer) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (!is_term)
            count <= count + 1'b1;
         if (is_term || last_slot)
            state <= ST_DONE;
      end
   end

   // NOTE: the register file has no reset; contents are only meaningful up
   // to count, and leaving it out of reset keeps it a plain flop array.
   always_ff @(posedge clk) begin
      if (xfer)
         mem[wr_ptr] <= in_bits;
   end

   // Indices past the physical entries (non power-of-two depth) read as 0.
   generate
      if (DEPTH == (1 << PTR_W)) begin : g_rd_full
         assign rd_bits = mem[rd_idx];
      end else begin : g_rd_guard
         assign rd_bits = (rd_idx < PTR_W'(DEPTH)) ? mem[rd_idx] : '0;
      end
   endgenerate

endmodule

// File: rtl/iact_spad_loader.sv
// ----------------------------------------------------------------------------
// iact_spad_loader -- per-PE input-activation scratchpad loader.
//
// Loads the CSC address and CSC data streams from the cluster iact switch
// into two independent scratchpads, detects each stream's terminator (or
// depth overflow) and raises load_done one cycle after both are complete.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_clear            synchronous pulse: discard contents, re-arm streams
//   bus (slave)           address and data valid/ready streams
//   addr_rd_idx/bits      combinational address scratchpad read
//   data_rd_idx/bits      combinational data scratchpad read
//   addr_count/data_count words stored per stream, terminator excluded
//   load_done             registered: both streams terminated
//   spad_overflow         (only with IACT_SPAD_OVERFLOW_ERR_EN) sticky flag,
//                         set when either stream ends by filling its depth
//
// Optional feature macro: IACT_SPAD_OVERFLOW_ERR_EN
// ----------------------------------------------------------------------------
module iact_spad_loader
   import iact_pkg::*;
#(
   parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
   parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load_clear,
   iact_spad_loader_if.slave                 bus,
   input  logic [$clog2(ADDR_DEPTH)-1:0]     addr_rd_idx,
   output logic [ADDR_W-1:0]                 addr_rd_bits,
   input  logic [$clog2(DATA_DEPTH)-1:0]     data_rd_idx,
   output logic [DATA_W-1:0]                 data_rd_bits,
   output logic [$clog2(ADDR_DEPTH+1)-1:0]   addr_count,
   output logic [$clog2(DATA_DEPTH+1)-1:0]   data_count,
`ifdef IACT_SPAD_OVERFLOW_ERR_EN
   output logic                              spad_overflow,
`endif
   output logic                              load_done
);

   logic addr_done, data_done;
   logic addr_ovf,  data_ovf;

   // A zero address at slot 0 is a legal first column pointer.
   iact_spad_stream #(
      .W         (ADDR_W),
      .DEPTH     (ADDR_DEPTH),
      .ZERO_CODE (ADDR_ZERO),
      .TERM_RULE (TERM_ZERO_NOT_FIRST)
   ) u_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (load_clear),
      .in_valid (bus.iact_address_in_valid),
      .in_ready (bus.iact_address_in_ready),
      .in_bits  (bus.iact_address_in_bits),
      .rd_idx   (addr_rd_idx),
      .rd_bits  (addr_rd_bits),
      .count    (addr_count),
      .done     (addr_done),
      .ovf_hit  (addr_ovf)
   );

   iact_spad_stream #(
      .W         (DATA_W),
      .DEPTH     (DATA_DEPTH),
      .ZERO_CODE (DATA_ZERO),
      .TERM_RULE (TERM_ANY_ZERO)
   ) u_data (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (load_clear),
      .in_valid (bus.iact_data_in_valid),
      .in_ready (bus.iact_data_in_ready),
      .in_bits  (bus.iact_data_in_bits),
      .rd_idx   (data_rd_idx),
      .rd_bits  (data_rd_bits),
      .count    (data_count),
      .done     (data_done),
      .ovf_hit  (data_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         load_done <= 1'b0;
      else if (load_clear)
         load_done <= 1'b0;
      else
         load_done <= addr_done && data_done;
   end

`ifdef IACT_SPAD_OVERFLOW_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         spad_overflow <= 1'b0;
      else if (load_clear)
         spad_overflow <= 1'b0;
      else if (addr_ovf || data_ovf)
         spad_overflow <= 1'b1;
   end
`else
   // Overflow still ends the stream; without the flag it is visible only as
   // count == DEPTH.
   logic unused_ovf;
   assign unused_ovf = addr_ovf | data_ovf;
`endif

endmodule

// File: tb/tb_iact_spad_loader.sv
// ----------------------------------------------------------------------------
// tb_iact_spad_loader -- self-checking bench for iact_spad_loader.
// A behavioural model tracks the words accepted per stream as simple lists
// and derives ready/count/done/load_done/overflow/read data from them.
// ----------------------------------------------------------------------------
module tb_iact_spad_loader;
   import iact_pkg::*;

   localparam int AD = ADDR_DEPTH_DEF;
   localparam int DD = DATA_DEPTH_DEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_clear = 1'b0;
   logic [3:0]        addr_rd_idx = '0;
   logic [ADDR_W-1:0] addr_rd_bits;
   logic [3:0]        data_rd_idx = '0;
   logic [DATA_W-1:0] data_rd_bits;
   logic [3:0]        addr_count;
   logic [4:0]        data_count;
   logic              load_done;
`ifdef IACT_SPAD_OVERFLOW_ERR_EN
   logic              spad_overflow;
`endif

   iact_spad_loader_if bus ();

   iact_spad_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_clear   (load_clear),
      .bus          (bus),
      .addr_rd_idx  (addr_rd_idx),
      .addr_rd_bits (addr_rd_bits),
      .data_rd_idx  (data_rd_idx),
      .data_rd_bits (data_rd_bits),
      .addr_count   (addr_count),
      .data_count   (data_count),
`ifdef IACT_SPAD_OVERFLOW_ERR_EN
      .spad_overflow(spad_overflow),
`endif
      .load_done    (load_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   int  m_a_n = 0, m_d_n = 0;          // words accepted since last clear
   bit  m_a_term = 0, m_d_term = 0;    // last accepted word was a terminator
   bit  m_a_done = 0, m_d_done = 0;
   bit  m_ld = 0, m_ovf = 0;
   logic [ADDR_W-1:0] a_shadow [AD];
   logic [DATA_W-1:0] d_shadow [DD];
   bit  a_known [AD];
   bit  d_known [DD];

   task automatic model_reset();
      m_a_n = 0; m_d_n = 0; m_a_term = 0; m_d_term = 0;
      m_a_done = 0; m_d_done = 0; m_ld = 0; m_ovf = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      bit both;
      if (!rst_n) begin
         model_reset();
      end else if (load_clear) begin
         model_reset();
      end else begin
         both = m_a_done && m_d_done;
         if (bus.iact_address_in_valid && !m_a_done) begin
            a_shadow[m_a_n] = bus.iact_address_in_bits;
            a_known[m_a_n]  = 1'b1;
            if (bus.iact_address_in_bits == 0 && m_a_n > 0) begin
               m_a_term = 1; m_a_done = 1;
            end else if (m_a_n + 1 == AD) begin
               m_a_done = 1; m_ovf = 1;
            end
            m_a_n++;
         end
         if (bus.iact_data_in_valid && !m_d_done) begin
            d_shadow[m_d_n] = bus.iact_data_in_bits;
            d_known[m_d_n]  = 1'b1;
            if (bus.iact_data_in_bits == 0) begin
               m_d_term = 1; m_d_done = 1;
            end else if (m_d_n + 1 == DD) begin
               m_d_done = 1; m_ovf = 1;
            end
            m_d_n++;
         end
         m_ld = both;
      end
   end

   // ---------------------------------------------------------- compare loop
   bit cmp_stop = 0;
   initial begin
      while (!cmp_stop) begin
         @(negedge clk);
         #1;
         check("addr_ready", 32'(bus.iact_address_in_ready), 32'(!m_a_done));
         check("data_ready", 32'(bus.iact_data_in_ready),    32'(!m_d_done));
         check("addr_count", 32'(addr_count), 32'(m_a_n - int'(m_a_term)));
         check("data_count", 32'(data_count), 32'(m_d_n - int'(m_d_term)));
         check("load_done",  32'(load_done),  32'(m_ld));
`ifdef IACT_SPAD_OVERFLOW_ERR_EN
         check("spad_overflow", 32'(spad_overflow), 32'(m_ovf));
`endif
         if (addr_rd_idx < AD && a_known[addr_rd_idx])
            check("addr_rd", 32'(addr_rd_bits), 32'(a_shadow[addr_rd_idx]));
         if (d_known[data_rd_idx])
            check("data_rd", 32'(data_rd_bits), 32'(d_shadow[data_rd_idx]));
      end
   end

   // ------------------------------------------------------- stimulus helpers
   task automatic idle();
      @(negedge clk);
      bus.iact_address_in_valid = 1'b0;
      bus.iact_data_in_valid    = 1'b0;
      load_clear = 1'b0;
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      bus.iact_address_in_valid = 1'b0;
      bus.iact_data_in_valid    = 1'b0;
      load_clear = 1'b1;
      @(negedge clk);
      load_clear = 1'b0;
   endtask

   task automatic send_addr(input logic [ADDR_W-1:0] w);
      @(negedge clk);
      bus.iact_address_in_valid = 1'b1;
      bus.iact_address_in_bits  = w;
      bus.iact_data_in_valid    = 1'b0;
   endtask

   task automatic send_data(input logic [DATA_W-1:0] w);
      @(negedge clk);
      bus.iact_data_in_valid    = 1'b1;
      bus.iact_data_in_bits     = w;
      bus.iact_address_in_valid = 1'b0;
   endtask

   task automatic read_addr(input int idx, input logic [ADDR_W-1:0] exp, input string name);
      addr_rd_idx = 4'(idx);
      #1;
      check(name, 32'(addr_rd_bits), 32'(exp));
   endtask

   // --------------------------------------------------------------- sequence
   initial begin
      logic [ADDR_W-1:0] t1 [4];
      t1[0] = 8'd3; t1[1] = 8'd5; t1[2] = 8'd7; t1[3] = 8'd0;
      bus.iact_address_in_valid = 1'b0;
      bus.iact_address_in_bits  = '0;
      bus.iact_data_in_valid    = 1'b0;
      bus.iact_data_in_bits     = '0;

      #12 rst_n = 1'b1;
      #1;
      check("rst_addr_ready", 32'(bus.iact_address_in_ready), 32'd1);
      check("rst_data_ready", 32'(bus.iact_data_in_ready), 32'd1);
      check("rst_addr_count", 32'(addr_count), 32'd0);
      check("rst_load_done",  32'(load_done), 32'd0);

      // Address 3,5,7,0 back to back.
      foreach (t1[i]) send_addr(t1[i]);
      idle();
      #1;
      check("t1_addr_count", 32'(addr_count), 32'd3);
      check("t1_addr_ready", 32'(bus.iact_address_in_ready), 32'd0);
      check("t1_model_count", 32'(m_a_n - int'(m_a_term)), 32'd3);
      foreach (t1[i]) read_addr(i, t1[i], "t1_addr_rd");

      // Address 0,4,0: leading zero is a normal word.
      clear_pulse();
      send_addr(8'd0); send_addr(8'd4); send_addr(8'd0);
      idle();
      #1;
      check("t2_addr_count", 32'(addr_count), 32'd2);
      check("t2_addr_ready", 32'(bus.iact_address_in_ready), 32'd0);
      read_addr(0, 8'd0, "t2_addr_rd0");
      read_addr(1, 8'd4, "t2_addr_rd1");

      // Data 1..15 then 0, address already done.
      for (int i = 1; i <= 15; i++) send_data(DATA_W'(i * 500 + 1));
      send_data('0);
      idle();
      #1;
      check("t3_load_done_early", 32'(load_done), 32'd0);
      check("t3_data_count", 32'(data_count), 32'd15);
      idle();
      #1;
      check("t3_load_done", 32'(load_done), 32'd1);

      // Clear with a simultaneous word 6, both while done and while ready.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         load_clear = 1'b1;
         bus.iact_address_in_valid = 1'b1;
         bus.iact_address_in_bits  = 8'd6;
         bus.iact_data_in_valid    = 1'b1;
         bus.iact_data_in_bits     = 13'd6;
         idle();
         #1;
         check("t5_addr_count", 32'(addr_count), 32'd0);
         check("t5_data_count", 32'(data_count), 32'd0);
         check("t5_addr_ready", 32'(bus.iact_address_in_ready), 32'd1);
         check("t5_load_done",  32'(load_done), 32'd0);
         read_addr(0, 8'd0, "t5_addr_rd0_not6");
      end

      // Nine non-zero address words: overflow into DONE.
      for (int i = 1; i <= 9; i++) send_addr(ADDR_W'(i * 11));
      send_addr(8'd99);  // offered but never accepted
      idle();
      #1;
      check("t4_addr_count", 32'(addr_count), 32'd9);
      check("t4_addr_ready", 32'(bus.iact_address_in_ready), 32'd0);
      check("t4_load_done",  32'(load_done), 32'd0);
      read_addr(8, 8'd99, "t4_addr_rd8");
`ifdef IACT_SPAD_OVERFLOW_ERR_EN
      check("t4_spad_overflow", 32'(spad_overflow), 32'd1);
`endif

      // Asynchronous reset mid-load.
      clear_pulse();
      send_data('0);
      send_addr(8'd1); send_addr(8'd2);
      idle();
      #1;
      check("t6_pre_addr_count", 32'(addr_count), 32'd2);
      check("t6_pre_data_ready", 32'(bus.iact_data_in_ready), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("t6_addr_ready", 32'(bus.iact_address_in_ready), 32'd1);
      check("t6_data_ready", 32'(bus.iact_data_in_ready), 32'd1);
      check("t6_addr_count", 32'(addr_count), 32'd0);
      check("t6_load_done",  32'(load_done), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Randomised episodes on both streams.
      for (int ep = 0; ep < 60; ep++) begin
         clear_pulse();
         for (int c = 0; c < int'($urandom_range(40, 5)); c++) begin
            @(negedge clk);
            load_clear = ($urandom_range(29, 0) == 0);
            if (!(bus.iact_address_in_valid && !bus.iact_address_in_ready)) begin
               bus.iact_address_in_valid = ($urandom_range(3, 0) != 0);
               bus.iact_address_in_bits  = ($urandom_range(6, 0) == 0) ? 8'd0 :
                                           ADDR_W'($urandom_range(255, 1));
            end
            if (!(bus.iact_data_in_valid && !bus.iact_data_in_ready)) begin
               bus.iact_data_in_valid = ($urandom_range(3, 0) != 0);
               bus.iact_data_in_bits  = ($urandom_range(9, 0) == 0) ? 13'd0 :
                                        DATA_W'($urandom_range(8191, 1));
            end
            addr_rd_idx = 4'($urandom_range(AD - 1, 0));
            data_rd_idx = 4'($urandom_range(DD - 1, 0));
         end
         idle();
         idle();
      end

      idle();
      idle();
      cmp_stop = 1;
      @(negedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
